bsg_link_isdr_rx: RTL
=====================

Name: bsg_link_isdr_rx

Overview:
- Receive-side SDR link endpoint; the counterpart to the output SDR PHY on the transmitting chip.
- Runs on the forwarded link clock and registers the incoming valid and data pins.
- Buffers received words in a small FIFO and presents them to the core with a valid/yumi handshake.
- Returns flow-control credits to the transmitter as token pulses, one pulse per 2^lg_decimation_p words consumed.

Parameters:
- width_p, no default (must be set), data width per link word.
- els_p, 8, FIFO depth; power of 2, >= 2. The transmitter's initial credit count equals els_p.
- lg_decimation_p, 2, log2 of words consumed per token pulse; >= 1 and <= log2(els_p).

Ports:
- clk_i  input  1  forwarded link clock; all state is on its rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- io_v_i  input  1  link valid from pins.
- io_data_i  input  width_p  link data from pins.
- core_v_o  output  1  FIFO head is valid.
- core_data_o  output  width_p  FIFO head data.
- core_yumi_i  input  1  core consumes the head this cycle.
- token_o  output  1  credit-return pulse to the transmitter.
- overflow_o  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - Clears io_v_r, FIFO read/write pointers, occupancy count, decimation counter, token_r and the overflow flag.
  - Outputs during and after reset: core_v_o=0, token_o=0, overflow_o=0.
  - Storage contents are don't-care.
  - Reset asserted mid-transfer discards all buffered words. No token is emitted for them.
- Input stage: io_v_i and io_data_i are registered every edge into io_v_r and io_data_r. There is no other logic between the pins and these flops.
- FIFO write: on an edge where io_v_r=1, io_data_r is written at the write pointer, provided count < els_p or core_yumi_i=1 that cycle.
- Latency: a word sampled at edge k is written at edge k+1. With the FIFO previously empty, core_v_o=1 and core_data_o=word immediately after edge k+1. There is no bypass around the FIFO.
- FIFO read:
  - core_v_o = (count != 0).
  - core_data_o is the head entry, read combinationally from storage.
  - core_yumi_i=1 pops the head at the edge.
  - core_yumi_i while core_v_o=0 is illegal. The block ignores it: no pointer or count change, no token credit.
- Pointers are log2(els_p) bits and wrap naturally. The count is log2(els_p)+1 bits.
- Simultaneous write and pop: count is unchanged and both pointers advance. This is allowed when full, since the pop frees the slot.
- Full with io_v_r=1 and no pop: the word is dropped, and pointers and count are unchanged. The overflow flag sets if the Optional Feature is enabled. This indicates a credit protocol violation by the transmitter.
- Token generation:
  - The decimation counter (lg_decimation_p bits) increments on each legal pop.
  - When a pop wraps the counter to 0, token_r is set for exactly the following cycle. token_o = token_r, directly from the flop.
  - Maximum token rate is one pulse per 2 cycles, so the pulse is always followed by at least one low cycle. The transmitter counts rising edges of token_o.
- Consumed words that have not completed a full decimation batch are never flushed as a partial token. The transmitter accounts for this in its credit count.

Optional Feature:
- Macro: BSG_LINK_ISDR_RX_OVERFLOW_DETECT_EN.
- Defined: overflow_o is a sticky flop. It is set at the edge where a write is dropped because the FIFO is full, and cleared only by reset_n_i.
- Not defined: overflow_o is tied to 0 and no flag flop is built. The drop behaviour on overflow is unchanged.

Test Plan:
- Reset release, then single word 0xA5 (width_p=8) on io_v_i at edge 3 -> core_v_o=1 with core_data_o=0xA5 after edge 4; core_v_o=0 before edge 4.
- Stream 8 words 0..7 (els_p=8) with core_yumi_i held high -> words pop in order 0..7; token_o pulses one cycle after the 4th and the 8th pop, exactly 2 pulses, each 1 cycle wide.
- Fill 8 words with yumi=0, then a 9th word (0xFF) arrives -> FIFO holds 0..7 unchanged, 0xFF dropped, overflow_o=1 and stays 1 (macro defined) or stays 0 (macro undefined).
- FIFO full, 9th word arrives with core_yumi_i=1 the same cycle -> word 0 pops, 0xFF written, count stays 8, no overflow.
- core_yumi_i=1 while empty for 3 cycles, then 4 legal pops -> exactly one token pulse, after the 4th legal pop.
- Assert reset_n_i low asynchronously (between edges) with 5 words buffered and the decimation counter at 3 -> core_v_o and token_o drop to 0 immediately; after release, 4 new pops are required before the next token.

Source files
------------

// File: rtl/bsg_link_isdr_rx.sv
// Receive-side SDR link endpoint: registers the pins, buffers words in a small FIFO and returns decimated credit tokens.
// Define BSG_LINK_ISDR_RX_OVERFLOW_DETECT_EN to build the sticky overflow flag; otherwise overflow_o is tied low.
module bsg_link_isdr_rx #(
  // No meaningful default: instantiators must set width_p. The value here only lets the file elaborate on its own.
  parameter int width_p         = 8,
  parameter int els_p           = 8,
  parameter int lg_decimation_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               io_v_i,
  input  logic [width_p-1:0] io_data_i,
  output logic               core_v_o,
  output logic [width_p-1:0] core_data_o,
  input  logic               core_yumi_i,
  output logic               token_o,
  output logic               overflow_o
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam logic [lg_els_lp:0] full_count_lp = (lg_els_lp+1)'(els_p);
  localparam logic [lg_decimation_p-1:0] dec_last_lp = '1;

  logic                       io_v_q, io_v_d;
  logic [width_p-1:0]         io_data_q, io_data_d;
  logic [width_p-1:0]         mem_q [els_p];
  logic [lg_els_lp-1:0]       wptr_q, wptr_d;
  logic [lg_els_lp-1:0]       rptr_q, rptr_d;
  logic [lg_els_lp:0]         count_q, count_d;
  logic [lg_decimation_p-1:0] dec_q, dec_d;
  logic                       token_q, token_d;
  logic                       pop;
  logic                       write_en;

  always_comb begin
    io_v_d    = io_v_i;
    io_data_d = io_data_i;
    // A yumi against an empty FIFO is ignored entirely, including for token credit.
    pop       = core_yumi_i && (count_q != '0);
    // When full, a same-cycle pop frees the slot the incoming word needs.
    write_en  = io_v_q && ((count_q != full_count_lp) || pop);
    wptr_d    = write_en ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
    count_d   = count_q + (lg_els_lp+1)'(write_en) - (lg_els_lp+1)'(pop);
    dec_d     = pop ? dec_q + 1'b1 : dec_q;
    token_d   = pop && (dec_q == dec_last_lp);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      io_v_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dec_q   <= '0;
      token_q <= 1'b0;
    end else begin
      io_v_q  <= io_v_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dec_q   <= dec_d;
      token_q <= token_d;
    end
  end

  // Data path carries no reset; contents are meaningless until the control state says otherwise.
  always_ff @(posedge clk_i) begin
    io_data_q <= io_data_d;
    if (write_en) begin
      mem_q[wptr_q] <= io_data_q;
    end
  end

  assign core_v_o    = (count_q != '0);
  assign core_data_o = mem_q[rptr_q];
  assign token_o     = token_q;

`ifdef BSG_LINK_ISDR_RX_OVERFLOW_DETECT_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q || (io_v_q && !write_en);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;
`else
  assign overflow_o = 1'b0;
`endif

endmodule
